// File: rtl/cpu_regfile_p.sv
// 6502 register file (A, X, Y, S, P, PC) with prioritised write channels and registered reads.
// Optional macro CPU_REGFILE_BYPASS_EN drives the outputs from next-state logic (same-cycle forwarding).
module cpu_regfile_p #(
  parameter int                DATA_W   = 8,
  parameter int                PC_W     = 16,
  parameter int                NUM_WR   = 3,
  parameter logic [PC_W-1:0]   RESET_PC = 16'h0000,
  parameter logic [DATA_W-1:0] RESET_S  = 8'hFD,
  parameter logic [7:0]        RESET_P  = 8'h24
) (
  input  logic                     clk,
  input  logic                     rst_x,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [3*NUM_WR-1:0]      wr_sel,
  input  logic [DATA_W*NUM_WR-1:0] wr_data,
  input  logic                     pc_load,
  input  logic [PC_W-1:0]          pc_in,
  input  logic                     pc_inc,
  input  logic                     sp_push,
  input  logic                     sp_pull,
  input  logic [7:0]               flag_set,
  input  logic [7:0]               flag_val,
  output logic [PC_W-1:0]          pc,
  output logic [DATA_W-1:0]        a,
  output logic [DATA_W-1:0]        x,
  output logic [DATA_W-1:0]        y,
  output logic [DATA_W-1:0]        s,
  output logic [7:0]               p,
  output logic                     collision
);

  localparam int T_A = 0, T_X = 1, T_Y = 2, T_S = 3, T_P = 4, T_PCL = 5, T_PCH = 6;

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] a_q, a_d, x_q, x_d, y_q, y_d, s_q, s_d;
  logic [7:0]        p_q, p_d, p_w;
  logic              coll_q, coll_d;

  logic [6:0]        hit;
  logic [DATA_W-1:0] wdat [7];

  // Per target, the first (lowest-index) enabled channel claims it; any later claimant is a collision.
  always_comb begin
    hit    = '0;
    coll_d = 1'b0;
    for (int t = 0; t < 7; t++) wdat[t] = '0;
    for (int t = 0; t < 7; t++) begin
      for (int c = 0; c < NUM_WR; c++) begin
        if (wr_en[c] && (wr_sel[3*c +: 3] == 3'(t))) begin
          if (!hit[t]) begin
            hit[t]  = 1'b1;
            wdat[t] = wr_data[DATA_W*c +: DATA_W];
          end else begin
            coll_d = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    a_d = hit[T_A] ? wdat[T_A] : a_q;
    x_d = hit[T_X] ? wdat[T_X] : x_q;
    y_d = hit[T_Y] ? wdat[T_Y] : y_q;

    pc_d = pc_q;
    if (pc_load) begin
      pc_d = pc_in;
    end else if (hit[T_PCL] || hit[T_PCH]) begin
      if (hit[T_PCL]) pc_d[DATA_W-1:0]      = wdat[T_PCL];
      if (hit[T_PCH]) pc_d[PC_W-1:DATA_W]   = wdat[T_PCH];
    end else if (pc_inc) begin
      pc_d = pc_q + PC_W'(1);
    end

    s_d = s_q;
    if (hit[T_S])                s_d = wdat[T_S];
    else if (sp_push && !sp_pull) s_d = s_q - DATA_W'(1);
    else if (sp_pull && !sp_push) s_d = s_q + DATA_W'(1);

    // Flag updates land on top of any channel write to P.
    p_w    = hit[T_P] ? wdat[T_P][7:0] : p_q;
    p_d    = (p_w & ~flag_set) | (flag_val & flag_set);
    p_d[5] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_x) begin
      pc_q   <= RESET_PC;
      a_q    <= '0;
      x_q    <= '0;
      y_q    <= '0;
      s_q    <= RESET_S;
      p_q    <= RESET_P;
      coll_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      a_q    <= a_d;
      x_q    <= x_d;
      y_q    <= y_d;
      s_q    <= s_d;
      p_q    <= p_d;
      coll_q <= coll_d;
    end
  end

  assign collision = coll_q;

`ifdef CPU_REGFILE_BYPASS_EN
  assign pc = rst_x ? RESET_PC : pc_d;
  assign a  = rst_x ? '0       : a_d;
  assign x  = rst_x ? '0       : x_d;
  assign y  = rst_x ? '0       : y_d;
  assign s  = rst_x ? RESET_S  : s_d;
  assign p  = rst_x ? RESET_P  : p_d;
`else
  assign pc = pc_q;
  assign a  = a_q;
  assign x  = x_q;
  assign y  = y_q;
  assign s  = s_q;
  assign p  = p_q;
`endif

endmodule
